dcdir_assoc: RTL and testbench

//  N-way set-associative L1 D-cache directory; successor to the direct-mapped single-array directory.

---
 rtl/dcdir_assoc_pkg.sv | 28 ++
 rtl/dcdir_plru.sv | 60 ++++++
 rtl/dcdir_assoc.sv | 212 +++++++++++++++++++++
 tb/tb_dcdir_assoc.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcdir_assoc_pkg.sv
// Shared definitions for the set-associative D-cache directory.
// Holds the flush FSM state encoding and the width helpers used by
// dcdir_assoc and dcdir_plru.
package dcdir_assoc_pkg;

  // Flush sequencer states
  typedef enum logic [1:0] {
    DIR_IDLE = 2'd0,
    DIR_WALK = 2'd1,
    DIR_DONE = 2'd2
  } dir_state_e;

  // Set index width for a given set count
  function automatic int unsigned idx_w(input int unsigned sets);
    return $clog2(sets);
  endfunction

  // Way index width for a given associativity
  function automatic int unsigned way_w(input int unsigned ways);
    return $clog2(ways);
  endfunction

  // Tree-PLRU needs one bit per internal node of a binary tree over the ways
  function automatic int unsigned plru_bits(input int unsigned ways);
    return ways - 1;
  endfunction

endpackage

// File: rtl/dcdir_plru.sv
// Combinational tree pseudo-LRU helper.
// Node n has children 2n+1 (lower half) and 2n+2 (upper half); a node bit
// of 1 points the victim search at the upper half.
// Ports:
//   lk_bits     PLRU bits of the lookup set
//   hit_way     way to promote to MRU in the lookup set
//   fill_bits   PLRU bits of the fill set
//   fill_way    way to promote to MRU in the fill set
//   victim_c    PLRU-selected victim of the lookup set
//   hit_bits_c  lookup-set bits after promoting hit_way
//   fill_bits_c fill-set bits after promoting fill_way
module dcdir_plru
  import dcdir_assoc_pkg::*;
#(
  parameter int unsigned WAYS = 4,
  localparam int unsigned WAY_W = way_w(WAYS),
  localparam int unsigned PLRU_W = plru_bits(WAYS)
) (
  input  logic [PLRU_W-1:0] lk_bits,
  input  logic [WAY_W-1:0]  hit_way,
  input  logic [PLRU_W-1:0] fill_bits,
  input  logic [WAY_W-1:0]  fill_way,
  output logic [WAY_W-1:0]  victim_c,
  output logic [PLRU_W-1:0] hit_bits_c,
  output logic [PLRU_W-1:0] fill_bits_c
);

  function automatic logic [WAY_W-1:0] child(input logic [WAY_W-1:0] n, input logic d);
    return WAY_W'(2 * int'(n) + 1 + int'(d));
  endfunction

  // Victim walk follows the bits; MRU update points each node on the path away
  always_comb begin
    logic [WAY_W-1:0] node;
    logic             dir;
    victim_c    = '0;
    hit_bits_c  = lk_bits;
    fill_bits_c = fill_bits;
    node        = '0;
    dir         = 1'b0;
    for (int l = 0; l < int'(WAY_W); l++) begin
      dir = lk_bits[node];
      victim_c[WAY_W-1-l] = dir;
      node = child(node, dir);
    end
    node = '0;
    for (int l = 0; l < int'(WAY_W); l++) begin
      dir = hit_way[WAY_W-1-l];
      hit_bits_c[node] = ~dir;
      node = child(node, dir);
    end
    node = '0;
    for (int l = 0; l < int'(WAY_W); l++) begin
      dir = fill_way[WAY_W-1-l];
      fill_bits_c[node] = ~dir;
      node = child(node, dir);
    end
  end

endmodule

// File: rtl/dcdir_assoc.sv
// N-way set-associative L1 D-cache directory: tag/valid per way, tag compare,
// tree-PLRU victim selection, invalidate-by-address and a sequenced flush.
// Optional feature macro: DCDIR_PARITY_EN (per-tag even parity; a bad way is
// treated as a miss, reported via lk_perr/lk_vic and invalidated).
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   lk_val/lk_idx/lk_tag           lookup request
//   lk_rdy                         lookup accepted (no flush in progress)
//   lk_rsp/lk_hit/lk_way/lk_vic    registered lookup response (cycle after accept)
//   lk_perr                        tag parity error with the response
//   fill_val/fill_idx/fill_way/fill_tag  install a tag, make way MRU
//   inv_val/inv_idx/inv_tag        invalidate matching line
//   flush_req/flush_busy/flush_done      whole-directory flush handshake
module dcdir_assoc
  import dcdir_assoc_pkg::*;
#(
  parameter int unsigned WAYS  = 4,
  parameter int unsigned SETS  = 64,
  parameter int unsigned TAG_W = 20,
  localparam int unsigned IDX_W  = idx_w(SETS),
  localparam int unsigned WAY_W  = way_w(WAYS),
  localparam int unsigned PLRU_W = plru_bits(WAYS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lk_val,
  input  logic [IDX_W-1:0] lk_idx,
  input  logic [TAG_W-1:0] lk_tag,
  output logic             lk_rdy,
  output logic             lk_rsp,
  output logic             lk_hit,
  output logic [WAY_W-1:0] lk_way,
  output logic [WAY_W-1:0] lk_vic,
  output logic             lk_perr,
  input  logic             fill_val,
  input  logic [IDX_W-1:0] fill_idx,
  input  logic [WAY_W-1:0] fill_way,
  input  logic [TAG_W-1:0] fill_tag,
  input  logic             inv_val,
  input  logic [IDX_W-1:0] inv_idx,
  input  logic [TAG_W-1:0] inv_tag,
  input  logic             flush_req,
  output logic             flush_busy,
  output logic             flush_done
);

`ifdef DCDIR_PARITY_EN
  localparam int unsigned ENT_W = TAG_W + 1;
`else
  localparam int unsigned ENT_W = TAG_W;
`endif

  logic [ENT_W-1:0]  tag_q   [SETS][WAYS];
  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   valid_d [SETS];
  logic [PLRU_W-1:0] plru_q  [SETS];
  logic [PLRU_W-1:0] plru_d  [SETS];

  dir_state_e       state_q;
  logic [IDX_W-1:0] cnt_q;

  logic             lk_acc, fill_en, inv_en;
  logic [WAYS-1:0]  match, bad, hit_vec, inv_match;
  logic [WAY_W-1:0] hit_way, inval_way, bad_way, vic, plru_vic;
  logic [PLRU_W-1:0] plru_hit_upd, plru_fill_upd;

  assign lk_rdy  = ~flush_busy;
  assign lk_acc  = lk_val & ~flush_busy;
  assign fill_en = fill_val & ~flush_busy;
  assign inv_en  = inv_val & ~flush_busy;

  // Tag compare for the lookup set and the invalidate set
  always_comb begin
    match     = '0;
    bad       = '0;
    inv_match = '0;
    for (int w = 0; w < int'(WAYS); w++) begin
      match[w]     = valid_q[lk_idx][w] && (tag_q[lk_idx][w][TAG_W-1:0] == lk_tag);
`ifdef DCDIR_PARITY_EN
      bad[w]       = valid_q[lk_idx][w] && (^tag_q[lk_idx][w]);
`endif
      inv_match[w] = valid_q[inv_idx][w] && (tag_q[inv_idx][w][TAG_W-1:0] == inv_tag);
    end
    hit_vec = match & ~bad;
  end

  // Lowest-index priority picks; victim preference: bad parity, invalid, PLRU
  always_comb begin
    hit_way   = '0;
    inval_way = '0;
    bad_way   = '0;
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (hit_vec[w])          hit_way   = WAY_W'(w);
      if (!valid_q[lk_idx][w]) inval_way = WAY_W'(w);
      if (bad[w])              bad_way   = WAY_W'(w);
    end
    if (|bad)                      vic = bad_way;
    else if (~&valid_q[lk_idx])    vic = inval_way;
    else                           vic = plru_vic;
  end

  dcdir_plru #(.WAYS(WAYS)) u_plru (
    .lk_bits     (plru_q[lk_idx]),
    .hit_way     (hit_way),
    .fill_bits   (plru_q[fill_idx]),
    .fill_way    (fill_way),
    .victim_c    (plru_vic),
    .hit_bits_c  (plru_hit_upd),
    .fill_bits_c (plru_fill_upd)
  );

  // Next valid/PLRU state; later assignments carry priority (fill over inv/hit)
  always_comb begin
    valid_d = valid_q;
    plru_d  = plru_q;
    if (state_q == DIR_WALK) begin
      valid_d[cnt_q] = '0;
      plru_d[cnt_q]  = '0;
    end else if (!flush_busy) begin
      if (inv_en) valid_d[inv_idx] = valid_d[inv_idx] & ~inv_match;
      if (lk_acc) valid_d[lk_idx]  = valid_d[lk_idx] & ~bad;
      if (fill_en) valid_d[fill_idx][fill_way] = 1'b1;
      if (lk_acc && (|hit_vec)) plru_d[lk_idx] = plru_hit_upd;
      if (fill_en) plru_d[fill_idx] = plru_fill_upd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < int'(SETS); s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      valid_q <= valid_d;
      plru_q  <= plru_d;
    end
  end

  // Tag storage is not reset; valid bits qualify it
  always_ff @(posedge clk) begin
    if (fill_en) begin
`ifdef DCDIR_PARITY_EN
      tag_q[fill_idx][fill_way] <= {^fill_tag, fill_tag};
`else
      tag_q[fill_idx][fill_way] <= fill_tag;
`endif
    end
  end

  // Lookup response register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lk_rsp <= 1'b0;
      lk_hit <= 1'b0;
      lk_way <= '0;
      lk_vic <= '0;
    end else begin
      lk_rsp <= lk_acc;
      lk_hit <= lk_acc & (|hit_vec);
      lk_way <= (lk_acc && (|hit_vec)) ? hit_way : '0;
      if (lk_acc) lk_vic <= vic;
    end
  end

`ifdef DCDIR_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lk_perr <= 1'b0;
    else        lk_perr <= lk_acc & (|bad);
  end
`else
  assign lk_perr = 1'b0;
`endif

  // Flush sequencer: one set cleared per WALK cycle, then a single DONE cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= DIR_IDLE;
      cnt_q      <= '0;
      flush_busy <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      case (state_q)
        DIR_IDLE: begin
          flush_done <= 1'b0;
          if (flush_req) begin
            state_q    <= DIR_WALK;
            flush_busy <= 1'b1;
          end
        end
        DIR_WALK: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == IDX_W'(SETS - 1)) begin
            state_q    <= DIR_DONE;
            flush_done <= 1'b1;
          end
        end
        DIR_DONE: begin
          state_q    <= DIR_IDLE;
          flush_busy <= 1'b0;
          flush_done <= 1'b0;
        end
        default: begin
          state_q    <= DIR_IDLE;
          flush_busy <= 1'b0;
          flush_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcdir_assoc.sv
// Self-checking bench for dcdir_assoc: directed scenarios plus randomized
// traffic compared against a set/way/PLRU-tree reference model.
module tb_dcdir_assoc;

  localparam int unsigned WAYS  = 4;
  localparam int unsigned SETS  = 64;
  localparam int unsigned TAG_W = 20;
  localparam int unsigned IDX_W = 6;
  localparam int unsigned WAY_W = 2;

  logic             clk, rst_n;
  logic             lk_val, lk_rdy, lk_rsp, lk_hit, lk_perr;
  logic [IDX_W-1:0] lk_idx, fill_idx, inv_idx;
  logic [TAG_W-1:0] lk_tag, fill_tag, inv_tag;
  logic [WAY_W-1:0] lk_way, lk_vic, fill_way;
  logic             fill_val, inv_val, flush_req, flush_busy, flush_done;

  dcdir_assoc #(.WAYS(WAYS), .SETS(SETS), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .lk_val(lk_val), .lk_idx(lk_idx), .lk_tag(lk_tag), .lk_rdy(lk_rdy),
    .lk_rsp(lk_rsp), .lk_hit(lk_hit), .lk_way(lk_way), .lk_vic(lk_vic),
    .lk_perr(lk_perr),
    .fill_val(fill_val), .fill_idx(fill_idx), .fill_way(fill_way), .fill_tag(fill_tag),
    .inv_val(inv_val), .inv_idx(inv_idx), .inv_tag(inv_tag),
    .flush_req(flush_req), .flush_busy(flush_busy), .flush_done(flush_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: per-line valid/tag, PLRU tree bits, flush as a busy countdown
  bit               mv [SETS][WAYS];
  logic [TAG_W-1:0] mt [SETS][WAYS];
  bit               mp [SETS][WAYS-1];
  int               flush_left;
  bit               e_rsp, e_hit, e_busy, e_done;
  int               e_way, e_vic;

  task automatic reset_model();
    for (int s = 0; s < int'(SETS); s++) begin
      for (int w = 0; w < int'(WAYS); w++) begin mv[s][w] = 0; mt[s][w] = '0; end
      for (int n = 0; n < int'(WAYS) - 1; n++) mp[s][n] = 0;
    end
    flush_left = 0; e_busy = 0; e_done = 0; e_rsp = 0;
  endtask

  // Victim search halves the way range, going upper when the node bit is set
  function automatic int m_victim(input int s);
    int node = 0, lo = 0, size = int'(WAYS);
    while (size > 1) begin
      int half = size / 2;
      if (mp[s][node]) begin lo += half; node = 2 * node + 2; end
      else node = 2 * node + 1;
      size = half;
    end
    return lo;
  endfunction

  // Touching a way points every node on its path at the other half
  task automatic m_touch(input int s, input int w);
    int node = 0, lo = 0, size = int'(WAYS);
    while (size > 1) begin
      int half = size / 2;
      if (w >= lo + half) begin mp[s][node] = 0; lo += half; node = 2 * node + 2; end
      else begin mp[s][node] = 1; node = 2 * node + 1; end
      size = half;
    end
  endtask

  task automatic model_cycle();
    int hw;
    e_rsp = lk_val && (flush_left == 0);
    e_hit = 0; e_way = 0;
    if (e_rsp) begin
      hw = -1;
      for (int w = 0; w < int'(WAYS); w++)
        if (hw < 0 && mv[lk_idx][w] && mt[lk_idx][w] == lk_tag) hw = w;
      e_hit = (hw >= 0);
      e_way = e_hit ? hw : 0;
      e_vic = -1;
      for (int w = 0; w < int'(WAYS); w++)
        if (e_vic < 0 && !mv[lk_idx][w]) e_vic = w;
      if (e_vic < 0) e_vic = m_victim(int'(lk_idx));
    end
    if (flush_left > 0) flush_left--;
    else begin
      if (inv_val)
        for (int w = 0; w < int'(WAYS); w++)
          if (mv[inv_idx][w] && mt[inv_idx][w] == inv_tag) mv[inv_idx][w] = 0;
      if (fill_val) begin
        mt[fill_idx][fill_way] = fill_tag;
        mv[fill_idx][fill_way] = 1;
      end
      if (e_rsp && e_hit && !(fill_val && fill_idx == lk_idx)) m_touch(int'(lk_idx), e_way);
      if (fill_val) m_touch(int'(fill_idx), int'(fill_way));
      if (flush_req) begin
        for (int s = 0; s < int'(SETS); s++) begin
          for (int w = 0; w < int'(WAYS); w++) mv[s][w] = 0;
          for (int n = 0; n < int'(WAYS) - 1; n++) mp[s][n] = 0;
        end
        flush_left = int'(SETS) + 1;
      end
    end
    e_busy = (flush_left > 0);
    e_done = (flush_left == 1);
  endtask

  task automatic compare();
    check("rsp", 32'(lk_rsp), 32'(e_rsp));
    if (e_rsp) begin
      check("hit", 32'(lk_hit), 32'(e_hit));
      check("way", 32'(lk_way), 32'(e_way));
      check("vic", 32'(lk_vic), 32'(e_vic));
      check("perr", 32'(lk_perr), 32'd0);
    end
    check("busy", 32'(flush_busy), 32'(e_busy));
    check("done", 32'(flush_done), 32'(e_done));
    check("rdy", 32'(lk_rdy), 32'(!e_busy));
  endtask

  task automatic step();
    model_cycle();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic idle_inputs();
    lk_val = 0; fill_val = 0; inv_val = 0; flush_req = 0;
  endtask

  task automatic do_lk(input logic [IDX_W-1:0] i, input logic [TAG_W-1:0] t);
    lk_val = 1; lk_idx = i; lk_tag = t;
    step();
    lk_val = 0;
  endtask

  task automatic do_fill(input logic [IDX_W-1:0] i, input logic [WAY_W-1:0] w,
                         input logic [TAG_W-1:0] t);
    fill_val = 1; fill_idx = i; fill_way = w; fill_tag = t;
    step();
    fill_val = 0;
  endtask

  int busy_cnt, done_cnt;

  initial begin
    rst_n = 0;
    lk_idx = '0; lk_tag = '0; fill_idx = '0; fill_way = '0; fill_tag = '0;
    inv_idx = '0; inv_tag = '0;
    idle_inputs();
    reset_model();
    #12;
    check("rst_rsp", 32'(lk_rsp), 32'd0);
    check("rst_hit", 32'(lk_hit), 32'd0);
    check("rst_way", 32'(lk_way), 32'd0);
    check("rst_vic", 32'(lk_vic), 32'd0);
    check("rst_perr", 32'(lk_perr), 32'd0);
    check("rst_busy", 32'(flush_busy), 32'd0);
    check("rst_done", 32'(flush_done), 32'd0);
    rst_n = 1;
    step();

    // Miss on an empty set
    do_lk(IDX_W'(5), TAG_W'(20'h12345));
    check("t1_rsp", 32'(lk_rsp), 32'd1);
    check("t1_hit", 32'(lk_hit), 32'd0);
    check("t1_vic", 32'(lk_vic), 32'd0);

    // Fill then hit; then PLRU after touching 0,1,2,3
    do_fill(IDX_W'(5), WAY_W'(2), TAG_W'(20'hABCDE));
    do_lk(IDX_W'(5), TAG_W'(20'hABCDE));
    check("t2_hit", 32'(lk_hit), 32'd1);
    check("t2_way", 32'(lk_way), 32'd2);
    do_fill(IDX_W'(5), WAY_W'(0), TAG_W'(20'h11111));
    do_fill(IDX_W'(5), WAY_W'(1), TAG_W'(20'h22222));
    do_fill(IDX_W'(5), WAY_W'(3), TAG_W'(20'h33333));
    do_lk(IDX_W'(5), TAG_W'(20'h11111)); check("t2_h0", 32'(lk_way), 32'd0);
    do_lk(IDX_W'(5), TAG_W'(20'h22222)); check("t2_h1", 32'(lk_way), 32'd1);
    do_lk(IDX_W'(5), TAG_W'(20'hABCDE)); check("t2_h2", 32'(lk_way), 32'd2);
    do_lk(IDX_W'(5), TAG_W'(20'h33333)); check("t2_h3", 32'(lk_way), 32'd3);
    do_lk(IDX_W'(5), TAG_W'(20'h99999));
    check("t2_miss", 32'(lk_hit), 32'd0);
    check("t2_plru_vic", 32'(lk_vic), 32'd0);

    // Lookup and fill in the same cycle: lookup sees pre-fill state
    fill_val = 1; fill_idx = IDX_W'(7); fill_way = WAY_W'(0); fill_tag = TAG_W'(1);
    do_lk(IDX_W'(7), TAG_W'(1));
    fill_val = 0;
    check("t3_rbw", 32'(lk_hit), 32'd0);
    do_lk(IDX_W'(7), TAG_W'(1));
    check("t3_hit", 32'(lk_hit), 32'd1);
    check("t3_way", 32'(lk_way), 32'd0);

    // Invalidate, then the freed way is the victim
    inv_val = 1; inv_idx = IDX_W'(5); inv_tag = TAG_W'(20'hABCDE);
    step();
    inv_val = 0;
    do_lk(IDX_W'(5), TAG_W'(20'hABCDE));
    check("t4_hit", 32'(lk_hit), 32'd0);
    check("t4_vic", 32'(lk_vic), 32'd2);

    // Full flush with lookups held high throughout
    for (int s = 10; s < 14; s++) do_fill(IDX_W'(s), WAY_W'(0), TAG_W'(20'h0F000 + s));
    flush_req = 1;
    step();
    flush_req = 0;
    busy_cnt = 0; done_cnt = 0;
    lk_val = 1; lk_idx = IDX_W'(10); lk_tag = TAG_W'(20'h0F00A);
    for (int c = 0; c < int'(SETS) + 10 && flush_busy; c++) begin
      busy_cnt++;
      if (flush_done) done_cnt++;
      check("t5_rdy", 32'(lk_rdy), 32'd0);
      step();
    end
    lk_val = 0;
    check("t5_busy_len", 32'(busy_cnt), 32'(SETS + 1));
    check("t5_done_cnt", 32'(done_cnt), 32'd1);
    for (int s = 10; s < 14; s++) begin
      do_lk(IDX_W'(s), TAG_W'(20'h0F000 + s));
      check("t5_flushed", 32'(lk_hit), 32'd0);
    end

    // Reset in the middle of a flush
    do_fill(IDX_W'(2), WAY_W'(1), TAG_W'(20'h00042));
    flush_req = 1;
    step();
    flush_req = 0;
    step(); step();
    rst_n = 0;
    #1;
    check("t5_rst_busy", 32'(flush_busy), 32'd0);
    check("t5_rst_done", 32'(flush_done), 32'd0);
    reset_model();
    #1;
    rst_n = 1;
    for (int c = 0; c < 4; c++) step();
    do_lk(IDX_W'(2), TAG_W'(20'h00042));
    check("t5_rst_miss", 32'(lk_hit), 32'd0);

    // Randomized traffic on a few sets with a small tag pool
    for (int c = 0; c < 1500; c++) begin
      lk_val    = 1'($urandom_range(0, 1));
      lk_idx    = IDX_W'($urandom_range(0, 3));
      lk_tag    = TAG_W'($urandom_range(0, 5));
      inv_val   = ($urandom_range(0, 7) == 0);
      inv_idx   = IDX_W'($urandom_range(0, 3));
      inv_tag   = TAG_W'($urandom_range(0, 5));
      fill_val  = ($urandom_range(0, 2) == 0);
      fill_idx  = IDX_W'($urandom_range(0, 3));
      fill_tag  = TAG_W'($urandom_range(0, 5));
      fill_way  = WAY_W'($urandom_range(0, WAYS - 1));
      // Keep tags unique within a set by refilling an existing copy in place
      for (int w = 0; w < int'(WAYS); w++)
        if (mv[fill_idx][w] && mt[fill_idx][w] == fill_tag) fill_way = WAY_W'(w);
      flush_req = ($urandom_range(0, 299) == 0);
      step();
    end
    idle_inputs();
    for (int c = 0; c < int'(SETS) + 3; c++) step();

`ifdef DCDIR_PARITY_EN
    do_fill(IDX_W'(3), WAY_W'(1), TAG_W'(20'h00005));
    dut.tag_q[3][1][TAG_W] = ~dut.tag_q[3][1][TAG_W];
    lk_val = 1; lk_idx = IDX_W'(3); lk_tag = TAG_W'(20'h00005);
    @(posedge clk);
    #1;
    lk_val = 0;
    check("t6_rsp", 32'(lk_rsp), 32'd1);
    check("t6_hit", 32'(lk_hit), 32'd0);
    check("t6_perr", 32'(lk_perr), 32'd1);
    check("t6_vic", 32'(lk_vic), 32'd1);
    check("t6_inval", 32'(dut.valid_q[3][1]), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
